pw_mem_arbiter: RTL and testbench
=================================

# pw_mem_arbiter

Two-requester arbiter sharing one downstream generic bus between the page walker (PTE reads) and the L1 data cache (fills/evictions). Sits between `page_walker`'s `mem_gen_bus_if` port, the data cache's memory-side port, and the memory/L2 bus. It latches each granted request, holds the grant until the downstream transaction completes, and bounds starvation of the lower-priority requester.

## Interface
- `PW_PRIORITY`, 1: 1 = page walker wins ties, 0 = cache wins ties.
- `STARVE_LIMIT`, 4: consecutive contested wins by the priority requester before the other is forced a grant; legal 1..15.
- `CLK` input 1: clock.
- `nRST` input 1: reset, asynchronous, active-low.
- `pw_bus_if` generic_bus_if.generic_bus: page walker side (addr, wdata, ren, wen, byte_en in; rdata, busy out).
- `dc_bus_if` generic_bus_if.generic_bus: data cache side, same signal set.
- `mem_bus_if` generic_bus_if.cpu: downstream bus.
- `owner` output 2: current owner, `bus_owner_t` (NONE/PW/CACHE), for perf counters.

## Operation
- FSM states are IDLE, GRANT_PW, GRANT_DC and DRAIN.
- A requester is pending when `ren | wen` is high on its port.
- **IDLE**
  - No pending requester: stay in IDLE.
  - One pending requester: grant it.
  - Both pending: grant the tie-winner set by `PW_PRIORITY`, unless `starve_cnt == STARVE_LIMIT`, in which case grant the other requester.
- **On grant**
  - Latch addr, wdata, ren, wen and byte_en into request registers.
  - Record the granted requester in `owner`.
- **GRANT_x**
  - Drive mem ren/wen/addr/wdata/byte_en from the latched registers only. Requester changes during the transaction are ignored.
  - Granted port `busy = mem busy`; granted port `rdata = mem rdata` (combinational).
  - Non-granted port: `busy = 1`, `rdata = 0`.
  - Mem busy low: the granted port sees `busy = 0` that same cycle. Next state is IDLE.
  - Granted requester drops both ren and wen while mem busy is high (e.g. walker abort): next state is DRAIN.
- **DRAIN**
  - Keep driving the latched request downstream; the memory cannot cancel.
  - Both ports see `busy = 1`.
  - Mem busy low: discard rdata, next state is IDLE.
- **Starvation counter `starve_cnt`** (4 bits)
  - Increments on a contested grant to the tie-winner; saturates at `STARVE_LIMIT`.
  - Clears on any grant to the tie-loser.
  - Unchanged on an uncontested grant to the tie-winner.

## Timing
- Reset values:
  - State IDLE; `owner` NONE; `starve_cnt` 0; latched registers 0.
  - mem ren/wen 0, mem addr/wdata 0, mem byte_en 0.
  - Both port `busy` 1, both port `rdata` 0.
- Arbitration latency: a request seen in IDLE in cycle N reaches the mem bus in cycle N+1.
- One IDLE bubble always follows completion. Back-to-back requests from the same requester each pay one arbitration cycle.
- Completion is the cycle in which mem busy is low while in GRANT_x. That is exactly one `busy = 0` cycle per transaction on the granted port.
- Both ports become pending in the same IDLE cycle: one grant, per the rules in Operation.
- The loser keeps its request asserted and keeps seeing busy=1 until it is granted.
- Requester asserts ren and wen together: the cycle is latched as-is and passed through. Legality is the requester's responsibility.
- nRST asserted mid-transaction:
  - Immediate return to reset values.
  - The downstream request is dropped.
  - The downstream slave must tolerate this (same as a system reset).
- A request withdrawn during IDLE before it is granted: nothing is issued.

## Structure
- `bus_owner_t` enum {OWNER_NONE, OWNER_PW, OWNER_DC} goes in the shared cache types package; perf counters and debug consume it.
- The FSM state enum and the latched-request struct stay local to the module.
- Single module; no sub-module. The starvation counter and request latch are inline.
- Target 150–250 lines.

## Test plan
- **Lone walker read.** Walker ren, addr 0x8000_1004; mem busy held 3 cycles then rdata 0x2000_0C01.
  - mem ren=1, addr 0x8000_1004 from cycle N+1.
  - Walker busy drops exactly once, with rdata 0x2000_0C01.
  - Cache busy=1 throughout.
- **Simultaneous requests, PW_PRIORITY=1.** Walker and cache request in the same cycle.
  - Walker is granted first.
  - Cache is granted after the IDLE bubble.
  - `owner` sequence PW, NONE, DC.
- **Starvation, STARVE_LIMIT=4.** Walker and cache both request continuously.
  - Grant order W,W,W,W,C,W,W,W,W,C.
  - `starve_cnt` clears to 0 at each cache grant.
- **Abort mid-walk.** Walker drops ren 1 cycle after grant; mem busy lasts 5 cycles.
  - State goes to DRAIN.
  - mem ren stays 1 with the latched addr until completion.
  - Walker never sees busy=0; return to IDLE follows.
- **Cache eviction write.** Cache wen, addr 0x8000_2000, wdata 0xDEAD_BEEF, byte_en 4'b1111; cache changes addr the cycle after grant.
  - mem sees the latched 0x8000_2000 / 0xDEAD_BEEF / 4'b1111 for the whole transaction.
- **Reset mid-transaction.** nRST pulsed during GRANT_DC.
  - All outputs return to the reset values asynchronously.
  - The next request is arbitrated normally.

Source files
------------

// File: rtl/pw_mem_arbiter_pkg.sv
// Shared cache-side types: bus widths and the bus owner encoding consumed by
// the arbiter, perf counters and debug logic.
package pw_mem_arbiter_pkg;

    localparam int WORD_W    = 32;
    localparam int BYTE_EN_W = WORD_W / 8;

    typedef logic [WORD_W-1:0]    word_t;
    typedef logic [BYTE_EN_W-1:0] byte_en_t;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_PW    = 2'd1,
        OWNER_DC    = 2'd2
    } bus_owner_t;

endpackage

// File: rtl/pw_mem_arbiter_if.sv
// Generic memory bus: the requester drives addr/wdata/ren/wen/byte_en and the
// responder returns rdata with busy held high until the access completes.
interface generic_bus_if;
    import pw_mem_arbiter_pkg::*;

    word_t    addr;
    word_t    wdata;
    word_t    rdata;
    logic     ren;
    logic     wen;
    logic     busy;
    byte_en_t byte_en;

    modport generic_bus (
        input  addr, wdata, ren, wen, byte_en,
        output rdata, busy
    );

    modport cpu (
        output addr, wdata, ren, wen, byte_en,
        input  rdata, busy
    );

endinterface

// File: rtl/pw_mem_arbiter.sv
// Arbitrates the page walker and the L1 data cache onto one downstream bus,
// latching each granted request and bounding starvation of the tie-loser.
module pw_mem_arbiter
    import pw_mem_arbiter_pkg::*;
#(
    parameter bit PW_PRIORITY  = 1'b1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                   CLK,
    input  logic                   nRST,
    generic_bus_if.generic_bus     pw_bus_if,
    generic_bus_if.generic_bus     dc_bus_if,
    generic_bus_if.cpu             mem_bus_if,
    output bus_owner_t             owner
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_PW,
        GRANT_DC,
        DRAIN
    } state_t;

    typedef struct packed {
        word_t    addr;
        word_t    wdata;
        logic     ren;
        logic     wen;
        byte_en_t byte_en;
    } req_t;

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state, next_state;
    req_t       req_q;
    logic [3:0] starve_cnt;

    logic pw_pend, dc_pend, contested, starved;
    logic grant_pw, grant_dc, winner_granted, loser_granted;

    assign pw_pend   = pw_bus_if.ren | pw_bus_if.wen;
    assign dc_pend   = dc_bus_if.ren | dc_bus_if.wen;
    assign contested = pw_pend & dc_pend;
    assign starved   = (starve_cnt == LIMIT);

    // Grant decision is only taken in IDLE; a starved tie-loser overrides priority.
    always_comb begin
        grant_pw = 1'b0;
        grant_dc = 1'b0;
        if (state == IDLE) begin
            if (contested) begin
                if (PW_PRIORITY ? !starved : starved) grant_pw = 1'b1;
                else                                  grant_dc = 1'b1;
            end else if (pw_pend) begin
                grant_pw = 1'b1;
            end else if (dc_pend) begin
                grant_dc = 1'b1;
            end
        end
    end

    assign winner_granted = PW_PRIORITY ? grant_pw : grant_dc;
    assign loser_granted  = PW_PRIORITY ? grant_dc : grant_pw;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) state <= IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (grant_pw)      next_state = GRANT_PW;
                else if (grant_dc) next_state = GRANT_DC;
            end
            GRANT_PW: begin
                if (!mem_bus_if.busy) next_state = IDLE;
                else if (!pw_pend)    next_state = DRAIN;
            end
            GRANT_DC: begin
                if (!mem_bus_if.busy) next_state = IDLE;
                else if (!dc_pend)    next_state = DRAIN;
            end
            DRAIN: begin
                if (!mem_bus_if.busy) next_state = IDLE;
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        pw_bus_if.busy  = 1'b1;
        pw_bus_if.rdata = '0;
        dc_bus_if.busy  = 1'b1;
        dc_bus_if.rdata = '0;
        case (state)
            GRANT_PW: begin
                pw_bus_if.busy  = mem_bus_if.busy;
                pw_bus_if.rdata = mem_bus_if.rdata;
            end
            GRANT_DC: begin
                dc_bus_if.busy  = mem_bus_if.busy;
                dc_bus_if.rdata = mem_bus_if.rdata;
            end
            default: ;
        endcase
    end

    // Downstream only ever sees the latched request, never the live requester.
    assign mem_bus_if.addr    = req_q.addr;
    assign mem_bus_if.wdata   = req_q.wdata;
    assign mem_bus_if.byte_en = req_q.byte_en;
    assign mem_bus_if.ren     = req_q.ren & (state != IDLE);
    assign mem_bus_if.wen     = req_q.wen & (state != IDLE);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            req_q      <= '0;
            owner      <= OWNER_NONE;
            starve_cnt <= '0;
        end else begin
            if (grant_pw) begin
                req_q <= '{pw_bus_if.addr, pw_bus_if.wdata, pw_bus_if.ren,
                           pw_bus_if.wen, pw_bus_if.byte_en};
                owner <= OWNER_PW;
            end else if (grant_dc) begin
                req_q <= '{dc_bus_if.addr, dc_bus_if.wdata, dc_bus_if.ren,
                           dc_bus_if.wen, dc_bus_if.byte_en};
                owner <= OWNER_DC;
            end else if (state != IDLE && next_state == IDLE) begin
                owner <= OWNER_NONE;
            end

            if (loser_granted)
                starve_cnt <= '0;
            else if (winner_granted && contested && !starved)
                starve_cnt <= starve_cnt + 4'd1;
        end
    end

endmodule

// File: tb/tb_pw_mem_arbiter.sv
// Directed self-checking bench for pw_mem_arbiter; the bench plays both
// requesters and the downstream memory.
module tb_pw_mem_arbiter;
    import pw_mem_arbiter_pkg::*;

    logic       CLK = 1'b0;
    logic       nRST;
    bus_owner_t owner;
    int         errors = 0;
    int         checks = 0;

    generic_bus_if pw_if ();
    generic_bus_if dc_if ();
    generic_bus_if mem_if ();

    pw_mem_arbiter #(
        .PW_PRIORITY (1'b1),
        .STARVE_LIMIT(4)
    ) dut (
        .CLK       (CLK),
        .nRST      (nRST),
        .pw_bus_if (pw_if),
        .dc_bus_if (dc_if),
        .mem_bus_if(mem_if),
        .owner     (owner)
    );

    always #5 CLK = ~CLK;

    // Inputs change 1ns after the rising edge; checks follow 1ns later.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle_inputs();
        pw_if.addr = '0; pw_if.wdata = '0; pw_if.ren = 1'b0; pw_if.wen = 1'b0; pw_if.byte_en = '0;
        dc_if.addr = '0; dc_if.wdata = '0; dc_if.ren = 1'b0; dc_if.wen = 1'b0; dc_if.byte_en = '0;
        mem_if.busy = 1'b1; mem_if.rdata = '0;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle_inputs();
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        idle_inputs();
        #3;
        checks++; if (owner !== OWNER_NONE) begin errors++; $display("[TB] FAIL reset_owner: got %0d expected %0d", owner, OWNER_NONE); end
        checks++; if ({mem_if.ren, mem_if.wen} !== 2'b00) begin errors++; $display("[TB] FAIL reset_mem_ren_wen: got %b expected 00", {mem_if.ren, mem_if.wen}); end
        checks++; if (mem_if.addr !== 32'h0 || mem_if.wdata !== 32'h0 || mem_if.byte_en !== 4'h0) begin errors++; $display("[TB] FAIL reset_mem_bus: got addr=%h wdata=%h be=%h expected zeros", mem_if.addr, mem_if.wdata, mem_if.byte_en); end
        checks++; if (pw_if.busy !== 1'b1 || dc_if.busy !== 1'b1) begin errors++; $display("[TB] FAIL reset_busy: got pw=%b dc=%b expected 1 1", pw_if.busy, dc_if.busy); end
        checks++; if (pw_if.rdata !== 32'h0 || dc_if.rdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_rdata: got pw=%h dc=%h expected 0 0", pw_if.rdata, dc_if.rdata); end
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
        tick(); #1;
        checks++; if (owner !== OWNER_NONE || mem_if.ren !== 1'b0) begin errors++; $display("[TB] FAIL reset_idle_after: got owner=%0d ren=%b expected 0 0", owner, mem_if.ren); end
    endtask

    task automatic test_lone_read();
        int drops = 0;
        do_reset();
        pw_if.ren = 1'b1; pw_if.addr = 32'h8000_1004;
        #1;
        checks++; if (mem_if.ren !== 1'b0) begin errors++; $display("[TB] FAIL lone_cycle_n_ren: got %b expected 0", mem_if.ren); end
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_if.busy  = (i < 3);
            mem_if.rdata = (i == 3) ? 32'h2000_0C01 : 32'h0;
            #1;
            checks++; if (mem_if.ren !== 1'b1 || mem_if.addr !== 32'h8000_1004) begin errors++; $display("[TB] FAIL lone_mem_req: got ren=%b addr=%h expected 1 80001004", mem_if.ren, mem_if.addr); end
            checks++; if (dc_if.busy !== 1'b1) begin errors++; $display("[TB] FAIL lone_dc_busy: got %b expected 1", dc_if.busy); end
            if (pw_if.busy === 1'b0) begin
                drops++;
                checks++; if (pw_if.rdata !== 32'h2000_0C01) begin errors++; $display("[TB] FAIL lone_rdata: got %h expected 20000c01", pw_if.rdata); end
            end
            tick();
        end
        pw_if.ren = 1'b0; mem_if.busy = 1'b1; mem_if.rdata = '0;
        #1;
        checks++; if (drops != 1) begin errors++; $display("[TB] FAIL lone_busy_drops: got %0d expected 1", drops); end
        checks++; if (owner !== OWNER_NONE || mem_if.ren !== 1'b0 || pw_if.busy !== 1'b1) begin errors++; $display("[TB] FAIL lone_idle: got owner=%0d ren=%b busy=%b expected 0 0 1", owner, mem_if.ren, pw_if.busy); end
        tick(); #1;
        checks++; if (owner !== OWNER_NONE) begin errors++; $display("[TB] FAIL lone_no_regrant: got %0d expected 0", owner); end
    endtask

    task automatic test_simultaneous();
        do_reset();
        mem_if.busy = 1'b0;
        pw_if.ren = 1'b1; pw_if.addr = 32'h8000_0100;
        dc_if.ren = 1'b1; dc_if.addr = 32'h8000_0200;
        #1;
        checks++; if (owner !== OWNER_NONE) begin errors++; $display("[TB] FAIL sim_owner0: got %0d expected 0", owner); end
        tick(); #1;
        checks++; if (owner !== OWNER_PW || mem_if.addr !== 32'h8000_0100) begin errors++; $display("[TB] FAIL sim_first_grant: got owner=%0d addr=%h expected 1 80000100", owner, mem_if.addr); end
        checks++; if (pw_if.busy !== 1'b0 || dc_if.busy !== 1'b1) begin errors++; $display("[TB] FAIL sim_first_busy: got pw=%b dc=%b expected 0 1", pw_if.busy, dc_if.busy); end
        tick(); pw_if.ren = 1'b0; #1;
        checks++; if (owner !== OWNER_NONE || mem_if.ren !== 1'b0 || dc_if.busy !== 1'b1) begin errors++; $display("[TB] FAIL sim_bubble: got owner=%0d ren=%b dcbusy=%b expected 0 0 1", owner, mem_if.ren, dc_if.busy); end
        tick(); #1;
        checks++; if (owner !== OWNER_DC || mem_if.addr !== 32'h8000_0200) begin errors++; $display("[TB] FAIL sim_second_grant: got owner=%0d addr=%h expected 2 80000200", owner, mem_if.addr); end
        checks++; if (dc_if.busy !== 1'b0 || pw_if.busy !== 1'b1) begin errors++; $display("[TB] FAIL sim_second_busy: got dc=%b pw=%b expected 0 1", dc_if.busy, pw_if.busy); end
        tick(); dc_if.ren = 1'b0; mem_if.busy = 1'b1; #1;
        checks++; if (owner !== OWNER_NONE) begin errors++; $display("[TB] FAIL sim_end_owner: got %0d expected 0", owner); end
    endtask

    task automatic test_starvation();
        bus_owner_t exp_owner [10] = '{OWNER_PW, OWNER_PW, OWNER_PW, OWNER_PW, OWNER_DC,
                                       OWNER_PW, OWNER_PW, OWNER_PW, OWNER_PW, OWNER_DC};
        logic [3:0] exp_cnt [10]   = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
        do_reset();
        mem_if.busy = 1'b0;
        pw_if.ren = 1'b1; pw_if.addr = 32'h8000_0300;
        dc_if.ren = 1'b1; dc_if.addr = 32'h8000_0400;
        for (int k = 0; k < 10; k++) begin
            tick(); #1;
            checks++; if (owner !== exp_owner[k]) begin errors++; $display("[TB] FAIL starve_order[%0d]: got %0d expected %0d", k, owner, exp_owner[k]); end
            checks++; if (dut.starve_cnt !== exp_cnt[k]) begin errors++; $display("[TB] FAIL starve_cnt[%0d]: got %0d expected %0d", k, dut.starve_cnt, exp_cnt[k]); end
            tick();
        end
        pw_if.ren = 1'b0; dc_if.ren = 1'b0; mem_if.busy = 1'b1;
        tick();
    endtask

    task automatic test_abort();
        do_reset();
        pw_if.ren = 1'b1; pw_if.addr = 32'h8000_3008;
        tick(); #1;
        checks++; if (mem_if.ren !== 1'b1 || pw_if.busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_g1: got ren=%b busy=%b expected 1 1", mem_if.ren, pw_if.busy); end
        tick();
        pw_if.ren = 1'b0; pw_if.addr = 32'h1111_0000;
        #1;
        checks++; if (mem_if.addr !== 32'h8000_3008 || pw_if.busy !== 1'b1) begin errors++; $display("[TB] FAIL abort_g2: got addr=%h busy=%b expected 80003008 1", mem_if.addr, pw_if.busy); end
        tick();
        for (int i = 0; i < 4; i++) begin
            mem_if.busy  = (i < 3);
            mem_if.rdata = (i == 3) ? 32'h0000_FFFF : 32'h0;
            #1;
            checks++; if (mem_if.ren !== 1'b1 || mem_if.addr !== 32'h8000_3008) begin errors++; $display("[TB] FAIL abort_drain_req[%0d]: got ren=%b addr=%h expected 1 80003008", i, mem_if.ren, mem_if.addr); end
            checks++; if (pw_if.busy !== 1'b1 || dc_if.busy !== 1'b1 || pw_if.rdata !== 32'h0) begin errors++; $display("[TB] FAIL abort_drain_busy[%0d]: got pw=%b dc=%b rdata=%h expected 1 1 0", i, pw_if.busy, dc_if.busy, pw_if.rdata); end
            tick();
        end
        mem_if.busy = 1'b1; mem_if.rdata = '0;
        #1;
        checks++; if (owner !== OWNER_NONE || mem_if.ren !== 1'b0) begin errors++; $display("[TB] FAIL abort_idle: got owner=%0d ren=%b expected 0 0", owner, mem_if.ren); end
    endtask

    task automatic test_evict_write();
        do_reset();
        dc_if.wen = 1'b1; dc_if.addr = 32'h8000_2000; dc_if.wdata = 32'hDEAD_BEEF; dc_if.byte_en = 4'b1111;
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) begin dc_if.addr = 32'h8000_2040; dc_if.wdata = 32'h0; dc_if.byte_en = 4'b0001; end
            mem_if.busy = (i < 2);
            #1;
            checks++; if (mem_if.wen !== 1'b1 || mem_if.ren !== 1'b0) begin errors++; $display("[TB] FAIL evict_wen[%0d]: got wen=%b ren=%b expected 1 0", i, mem_if.wen, mem_if.ren); end
            checks++; if (mem_if.addr !== 32'h8000_2000 || mem_if.wdata !== 32'hDEAD_BEEF || mem_if.byte_en !== 4'b1111) begin errors++; $display("[TB] FAIL evict_latched[%0d]: got %h/%h/%b expected 80002000/deadbeef/1111", i, mem_if.addr, mem_if.wdata, mem_if.byte_en); end
            checks++; if (dc_if.busy !== (i < 2)) begin errors++; $display("[TB] FAIL evict_dc_busy[%0d]: got %b expected %b", i, dc_if.busy, (i < 2)); end
            tick();
        end
        dc_if.wen = 1'b0; mem_if.busy = 1'b1;
        #1;
        checks++; if (owner !== OWNER_NONE || mem_if.wen !== 1'b0) begin errors++; $display("[TB] FAIL evict_idle: got owner=%0d wen=%b expected 0 0", owner, mem_if.wen); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        dc_if.ren = 1'b1; dc_if.addr = 32'h8000_5000;
        mem_if.rdata = 32'h0000_1234;
        tick(); #1;
        checks++; if (owner !== OWNER_DC || dc_if.rdata !== 32'h0000_1234) begin errors++; $display("[TB] FAIL rmid_grant: got owner=%0d rdata=%h expected 2 00001234", owner, dc_if.rdata); end
        #2 nRST = 1'b0;
        #1;
        checks++; if (owner !== OWNER_NONE || mem_if.ren !== 1'b0 || mem_if.addr !== 32'h0) begin errors++; $display("[TB] FAIL rmid_async: got owner=%0d ren=%b addr=%h expected 0 0 0", owner, mem_if.ren, mem_if.addr); end
        checks++; if (dc_if.busy !== 1'b1 || dc_if.rdata !== 32'h0) begin errors++; $display("[TB] FAIL rmid_port: got busy=%b rdata=%h expected 1 0", dc_if.busy, dc_if.rdata); end
        dc_if.ren = 1'b0; mem_if.rdata = '0;
        tick();
        nRST = 1'b1;
        pw_if.ren = 1'b1; pw_if.addr = 32'h8000_6000;
        tick(); #1;
        checks++; if (owner !== OWNER_PW || mem_if.ren !== 1'b1 || mem_if.addr !== 32'h8000_6000) begin errors++; $display("[TB] FAIL rmid_next: got owner=%0d ren=%b addr=%h expected 1 1 80006000", owner, mem_if.ren, mem_if.addr); end
        pw_if.ren = 1'b0;
    endtask

    initial begin
        test_reset();
        test_lone_read();
        test_simultaneous();
        test_starvation();
        test_abort();
        test_evict_write();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
